// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_e;

endpackage

// File: rtl/shift_stage.sv
// One shifter layer: conditional shift by DIST selected by one amount bit,
// followed by a payload register that holds while the pipe is stalled.
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIST  = 1,
    parameter int unsigned SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_amt,
    input  shift_op_e        in_op,
    input  logic             in_carry,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_amt,
    output shift_op_e        out_op,
    output logic             out_carry,
    output logic [WIDTH-1:0] nxt_data
);

    localparam int unsigned BIT = $clog2(DIST);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SW-1:0]    amt;
        shift_op_e        op;
        logic             carry;
    } payload_t;

    payload_t         pay_d, pay_q;
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] shifted;
    logic             shift_carry;

    always_comb begin
        shifted     = in_data;
        shift_carry = in_carry;
        if (in_amt[BIT]) begin
            case (in_op)
                SHIFT_SLL: begin
                    shifted     = in_data << DIST;
                    shift_carry = in_data[WIDTH-DIST];
                end
                SHIFT_SRL: begin
                    shifted     = in_data >> DIST;
                    shift_carry = in_data[DIST-1];
                end
                SHIFT_SRA: begin
                    shifted     = $signed(in_data) >>> DIST;
                    shift_carry = in_data[DIST-1];
                end
                default: begin
                    shifted     = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
                    shift_carry = in_data[DIST-1];
                end
            endcase
        end
    end

    // Bubbles advance exactly like full beats; only the global stall holds.
    always_comb begin
        pay_d   = pay_q;
        valid_d = valid_q;
        if (!stall) begin
            pay_d.data  = shifted;
            pay_d.amt   = in_amt;
            pay_d.op    = in_op;
            pay_d.carry = shift_carry;
            valid_d     = in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pay_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pay_q   <= pay_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = pay_q.data;
    assign out_amt   = pay_q.amt;
    assign out_op    = pay_q.op;
    assign out_carry = pay_q.carry;
    assign nxt_data  = shifted;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR), one register per shift layer,
// valid/ready handshake with a single global stall.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    logic                     stall;
    logic [SW:0]              valid_s;
    logic [SW:0][WIDTH-1:0]   data_s;
    logic [SW:0][SW-1:0]      amt_s;
    shift_op_e [SW:0]         op_s;
    logic [SW:0]              carry_s;
    logic [SW-1:0][WIDTH-1:0] nxt_s;
    logic                     zero_d, zero_q;
    logic                     unused_bits;

    assign stall    = valid_s[SW] & ~out_ready;
    assign in_ready = ~stall;

    assign valid_s[0] = in_valid;
    assign data_s[0]  = in_data;
    assign amt_s[0]   = in_amt;
    assign op_s[0]    = shift_op_e'(in_op);
    assign carry_s[0] = 1'b0;

    for (genvar k = 0; k < SW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (2 ** k),
            .SW    (SW)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .stall     (stall),
            .in_valid  (valid_s[k]),
            .in_data   (data_s[k]),
            .in_amt    (amt_s[k]),
            .in_op     (op_s[k]),
            .in_carry  (carry_s[k]),
            .out_valid (valid_s[k+1]),
            .out_data  (data_s[k+1]),
            .out_amt   (amt_s[k+1]),
            .out_op    (op_s[k+1]),
            .out_carry (carry_s[k+1]),
            .nxt_data  (nxt_s[k])
        );
    end

    // Zero flag is taken from the last layer's pre-register result so it
    // lands in the same cycle as out_data.
    always_comb begin
        zero_d = zero_q;
        if (!stall) begin
            zero_d = (nxt_s[SW-1] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign unused_bits = ^{amt_s[SW], op_s[SW], nxt_s[SW-2:0]};

    assign out_valid = valid_s[SW];
    assign out_data  = data_s[SW];
    assign out_carry = carry_s[SW];
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Directed self-checking bench for shift_pipe at WIDTH=8 (latency 3).
module tb_shift_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic [1:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_carry;
    logic       out_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Send one beat with out_ready=1 and check latency and result.
    task automatic run_beat(input string tag, input logic [7:0] din, input logic [2:0] amt,
                            input logic [1:0] op, input logic [7:0] exp_d,
                            input logic exp_c, input logic exp_z);
        int unsigned lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = din;
        in_amt    = amt;
        in_op     = op;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"},   32'(lat),       32'd3);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(exp_d));
        chk({tag, "_carry"}, 32'(out_carry), 32'(exp_c));
        chk({tag, "_zero"},  32'(out_zero),  32'(exp_z));
    endtask

    initial begin
        int sent;
        int recv;
        int stalls;

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        in_amt    = 3'd0;
        in_op     = 2'b00;
        out_ready = 1'b1;

        // Reset wins over a simultaneous input beat.
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_carry", 32'(out_carry), 32'd0);
        chk("rst_zero",  32'(out_zero),  32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rst_no_beat", 32'(out_valid), 32'd0);
        end

        run_beat("sll3",    8'h96, 3'd3, 2'b00, 8'hB0, 1'b0, 1'b0);
        run_beat("sra2",    8'h96, 3'd2, 2'b10, 8'hE5, 1'b1, 1'b0);
        run_beat("srl2",    8'h96, 3'd2, 2'b01, 8'h25, 1'b1, 1'b0);
        run_beat("ror4",    8'h96, 3'd4, 2'b11, 8'h69, 1'b0, 1'b0);
        run_beat("sll7z",   8'h80, 3'd7, 2'b00, 8'h00, 1'b0, 1'b1);
        run_beat("sra7",    8'h96, 3'd7, 2'b10, 8'hFF, 1'b0, 1'b0);
        run_beat("srl7",    8'h96, 3'd7, 2'b01, 8'h01, 1'b0, 1'b0);
        run_beat("ror1",    8'h01, 3'd1, 2'b11, 8'h80, 1'b1, 1'b0);
        run_beat("amt0sll", 8'h5A, 3'd0, 2'b00, 8'h5A, 1'b0, 1'b0);
        run_beat("amt0srl", 8'h5A, 3'd0, 2'b01, 8'h5A, 1'b0, 1'b0);
        run_beat("amt0sra", 8'h5A, 3'd0, 2'b10, 8'h5A, 1'b0, 1'b0);
        run_beat("amt0ror", 8'h5A, 3'd0, 2'b11, 8'h5A, 1'b0, 1'b0);

        // Backpressure: six back-to-back SLL-by-1 beats, consumer stalls cycles 3..8.
        sent   = 0;
        recv   = 0;
        stalls = 0;
        for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 3 && cyc <= 8);
            if (sent < 6) begin
                in_valid = 1'b1;
                in_data  = 8'(sent + 1);
                in_amt   = 3'd1;
                in_op    = 2'b00;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (out_valid) begin
                if (!out_ready) begin
                    stalls++;
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    chk("bp_hold",     32'(out_data), 32'((recv + 1) * 2));
                    chk("bp_hold_c",   32'(out_carry), 32'd0);
                end else begin
                    chk("bp_data", 32'(out_data), 32'((recv + 1) * 2));
                    recv++;
                end
            end
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_sent",   32'(sent),   32'd6);
        chk("bp_recv",   32'(recv),   32'd6);
        chk("bp_stalls", 32'(stalls), 32'd6);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_no_extra", 32'(out_valid), 32'd0);
        end

        // Reset with three beats in flight.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'((i + 1) * 17);
            in_amt   = 3'd1;
            in_op    = 2'b00;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data",  32'(out_data),  32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_flush", 32'(out_valid), 32'd0);
        end
        run_beat("post_rst", 8'h0F, 3'd1, 2'b01, 8'h07, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter for the datapath ALU. Successor to the fixed 8-bit combinational right shifter.
- Supports four shift modes at any power-of-two width, with one register stage per shift layer.
- Valid/ready handshake on input and output, with full backpressure.
- Produces a carry (last bit shifted out) and a zero flag for the status register.

Parameters:
- WIDTH, 8, data width; power of two, minimum 4.
- SW, $clog2(WIDTH), shift-amount width; equals the number of pipeline stages. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_data  in  WIDTH  operand
- in_amt  in  SW  shift amount, 0..WIDTH-1
- in_op  in  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts the result
- out_data  out  WIDTH  shifted result
- out_carry  out  1  last bit shifted out; 0 when amount is 0
- out_zero  out  1  out_data == 0

Behaviour:
- Reset (rst=1 at a clk edge): every stage valid bit clears to 0; out_valid=0, out_data=0, out_carry=0, out_zero=0. Reset wins over any simultaneous handshake. A reset mid-stream discards all in-flight beats, with no partial output.
- Accept: a beat is taken when in_valid && in_ready at a clk edge.
- Stage k (k=0..SW-1) shifts by 2^k when amt[k]=1, otherwise passes data through. Op, remaining amount bits and carry travel with the data in each stage register.
- Per-stage fill rules, with d = 2^k:
  - SLL: vacated LSBs get 0; carry = data[WIDTH-d].
  - SRL: vacated MSBs get 0; carry = data[d-1].
  - SRA: vacated MSBs get data[WIDTH-1] of the stage input; carry = data[d-1].
  - ROR: rotated bits wrap to the MSBs; carry = data[d-1], which therefore equals final out_data[WIDTH-1].
  - Inactive stage: carry passes unchanged. Carry enters stage 0 as 0.
- Latency: exactly SW cycles from accept to out_valid with no stall (WIDTH=8 gives 3 cycles).
- Throughput: one beat per cycle.
- Backpressure: a single global stall, stall = out_valid && !out_ready.
  - When stalled, every stage holds.
  - in_ready = !stall. It is combinational from out_ready, with no dependence on in_valid.
- Bubbles: empty stages advance like full ones; bubbles are not squeezed out.
- Simultaneous accept at input and drain at output in the same cycle is legal and loses nothing.
- Ordering: results leave strictly in input order. No beat is dropped or duplicated.
- out_zero is registered alongside out_data in the final stage, not decoded from the output.
- Holding rule: out_data, out_carry, out_zero hold stable while out_valid=1 and out_ready=0.
- in_amt >= WIDTH cannot be encoded. in_op is fully decoded; there is no illegal op.

Decomposition:
- Package shift_pkg:
  - op encodings SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_ROR=2'b11
  - a stage-payload struct {data, amt, op, carry}
- Sub-module shift_stage: one layer of the shifter.
  - Parameters WIDTH and DIST (2^k).
  - Combinational shift plus carry select, then a register with hold-on-stall and a valid bit.
- shift_pipe instantiates SW copies of shift_stage in a generate loop, plus the stall logic and zero-flag register.

Test Plan (WIDTH=8, latency 3):
- SLL: in_data=0x96, amt=3, op=00, out_ready=1 -> 3 cycles later out_data=0xB0, carry=0, zero=0.
- SRA vs SRL: 0x96 amt=2 op=10 -> out_data=0xE5, carry=1; the same operands with op=01 -> out_data=0x25, carry=1.
- ROR and zero flag:
  - 0x96 amt=4 op=11 -> out_data=0x69, carry=0.
  - 0x80 amt=7 op=00 -> out_data=0x00, zero=1, carry=0 (bit shifted out last is 0x80 bit1 = 0).
- Amount zero: 0x5A amt=0 for each op -> out_data=0x5A, carry=0, zero=0 in all four cases.
- Backpressure:
  - Stimulus: back-to-back beats 0x01..0x06 (SLL amt=1); hold out_ready=0 from cycle 3 to cycle 8.
  - Required: in_ready drops once the pipe is full; outputs hold stable during the stall.
  - After release: results 0x02,0x04,...,0x0C in order, none lost or repeated.
- Reset mid-flight: assert rst for 1 cycle with 3 beats in flight -> out_valid=0 for the next SW cycles; first new beat emerges with correct latency; no stale data appears.
